led_scan_ctrl: RTL
==================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 32: columns shifted per row, power of two, at least 2.
REQ-002 SHALL have parameter ROW_BITS, default 4: row-address width; rows = 2^ROW_BITS.
REQ-003 SHALL have parameter ON_CYCLES, default 64: oe_n-low cycles per row, at least 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port rd_addr  output  ROW_BITS+log2(COLS)  frame-buffer read address {shift_row, col}, registered.
REQ-008 SHALL have port rd_data  input  6  {r1,g1,b1,r2,g2,b2}, valid the cycle after rd_addr.
REQ-009 SHALL have port sdata  output  6  panel serial data, registered.
REQ-010 SHALL have port sclk  output  1  panel shift clock.
REQ-011 SHALL have port lat  output  1  panel latch strobe, active-high.
REQ-012 SHALL have port oe_n  output  1  panel output enable, active-low.
REQ-013 SHALL have port row_addr  output  ROW_BITS  displayed row.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 SHALL implement FSM states IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
REQ-016 IDLE SHALL go to PREFETCH when en=1, else stay; oe_n=1, sclk=0, lat=0 in IDLE.
REQ-017 PREFETCH (1 cycle) SHALL drive rd_addr={shift_row,0}, then go to SHIFT with col=0.
REQ-018 SHIFT SHALL spend 2 cycles per column: phase 0 sclk=0 with sdata loaded from rd_data; phase 1 sclk=1, sdata held, rd_addr={shift_row,col+1}.
REQ-019 In SHIFT, col SHALL increment after phase 1; after phase 1 of col=COLS-1, FSM SHALL go to BLANK; SHIFT lasts exactly 2*COLS cycles.
REQ-020 BLANK (1 cycle) SHALL drive oe_n=1, sclk=0.
REQ-021 LATCH (1 cycle) SHALL drive lat=1, oe_n=1, and load row_addr<=shift_row at its end.
REQ-022 DISPLAY SHALL drive oe_n=0 for exactly ON_CYCLES cycles, lat=0, sclk=0; oe_n SHALL be 1 in every other state.
REQ-023 At DISPLAY end, shift_row SHALL increment, wrapping 2^ROW_BITS-1 to 0.
REQ-024 At DISPLAY end when shift_row was 2^ROW_BITS-1, frame_done SHALL pulse high for exactly 1 cycle.
REQ-025 At DISPLAY end, en SHALL be sampled: en=1 goes to PREFETCH, en=0 goes to IDLE.
REQ-026 en SHALL be ignored outside IDLE and DISPLAY end; a row in progress always completes.
REQ-027 Row period SHALL be 3+2*COLS+ON_CYCLES cycles, and lat and oe_n=0 SHALL never be asserted in the same cycle.
REQ-028 shift_row SHALL NOT reset on en=0, so scanning resumes at the next row.

Reset
REQ-029 RST=1 SHALL immediately, without waiting for clk, force state=IDLE, shift_row=0, col=0, row_addr=0, rd_addr=0, sdata=0, sclk=0, lat=0, oe_n=1, frame_done=0.
REQ-030 RST asserted mid-SHIFT or mid-DISPLAY SHALL abort the row with no lat pulse; after release, scanning restarts at row 0 on the first clk with en=1.

Verification
Bench configuration: COLS=4, ROW_BITS=2, ON_CYCLES=3, so row period = 14 cycles.
REQ-031 SHALL cover: RST pulse mid-SHIFT -> outputs at reset values before the next clk edge, and oe_n=1.
REQ-032 SHALL cover: en=1 from IDLE, rd_data=f(addr)=addr[5:0] -> 4 sclk rising edges per row, with sdata at each rise = 0,1,2,3 for row 0 and 4,5,6,7 for row 1.
REQ-033 SHALL cover: steady scan -> lat high 1 cycle at cycle offset 10 of each row, oe_n low cycles 11-13, and row_addr sequence 0,1,2,3,0.
REQ-034 SHALL cover: steady scan -> frame_done high exactly once per 56 cycles, coincident with the DISPLAY end of row 3.
REQ-035 SHALL cover: en dropped during SHIFT of row 1 -> row 1 latches and displays, then IDLE with oe_n=1; en re-raised -> next shifted row is 2.
REQ-036 SHALL cover: all runs -> an assertion that lat and ~oe_n are never both high, and that sclk is never high outside SHIFT.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl -- row-scanning driver for a HUB75-style RGB LED panel.
//
// Each row is shifted out one column per two clocks: sclk low, then sclk high.
// The row is then blanked, latched, and displayed for ON_CYCLES clocks while
// the next row waits for its turn. Pixel data comes from an external frame
// buffer with one cycle of read latency.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   RST        asynchronous active-high reset
//   en         scan enable, sampled in IDLE and at the end of DISPLAY
//   rd_addr    frame-buffer read address {shift_row, col} (registered)
//   rd_data    {r1,g1,b1,r2,g2,b2}, valid the cycle after rd_addr
//   sdata      panel serial data (registered)
//   sclk       panel shift clock
//   lat        panel latch strobe, active-high
//   oe_n       panel output enable, active-low
//   row_addr   row currently displayed
//   frame_done one-cycle pulse on the last DISPLAY cycle of the last row

// Protocol checker: the latch strobe never overlaps lit LEDs, and the shift
// clock only rises while a row is being shifted.
module led_scan_ctrl_chk (
  input logic clk,
  input logic RST,
  input logic lat,
  input logic oe_n,
  input logic sclk,
  input logic in_shift
);

  a_lat_vs_oe : assert property (@(posedge clk) disable iff (RST) !(lat && !oe_n));
  a_sclk_in_shift : assert property (@(posedge clk) disable iff (RST) (!sclk || in_shift));

endmodule

module led_scan_ctrl #(
  parameter int COLS      = 32,
  parameter int ROW_BITS  = 4,
  parameter int ON_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               RST,
  input  logic                               en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]   rd_addr,
  input  logic [5:0]                         rd_data,
  output logic [5:0]                         sdata,
  output logic                               sclk,
  output logic                               lat,
  output logic                               oe_n,
  output logic [ROW_BITS-1:0]                row_addr,
  output logic                               frame_done
);

  localparam int CW  = $clog2(COLS);
  localparam int AW  = ROW_BITS + CW;
  localparam int OCW = $clog2(ON_CYCLES + 1);

  localparam logic [CW-1:0]       COL_LAST = CW'(COLS - 1);
  localparam logic [OCW-1:0]      ON_LAST  = OCW'(ON_CYCLES - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = {ROW_BITS{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    SHIFT    = 3'd2,
    BLANK    = 3'd3,
    LATCH    = 3'd4,
    DISPLAY  = 3'd5
  } state_t;

  state_t                state_r;
  state_t                next_s;
  logic [CW-1:0]         col_r;
  logic                  phase_r;
  logic [OCW-1:0]        on_cnt_r;
  logic [OCW-1:0]        on_cnt_next_s;
  logic [ROW_BITS-1:0]   shift_row_r;
  logic [ROW_BITS-1:0]   shift_row_next_s;
  logic                  last_disp_next_s;
  logic                  shift_phase0_s;
  logic                  in_shift_s;

  logic [AW-1:0]         rd_addr_r;
  logic [5:0]            sdata_r;
  logic                  sclk_r;
  logic                  lat_r;
  logic                  oe_n_r;
  logic [ROW_BITS-1:0]   row_addr_r;
  logic                  frame_done_r;

  // Next-state logic plus the next values of the row and on-time counters.
  always_comb begin
    next_s           = state_r;
    shift_row_next_s = shift_row_r;
    on_cnt_next_s    = {OCW{1'b0}};
    case (state_r)
      IDLE: begin
        if (en) next_s = PREFETCH;
        else    next_s = IDLE;
      end
      PREFETCH: next_s = SHIFT;
      SHIFT: begin
        if (phase_r && (col_r == COL_LAST)) next_s = BLANK;
        else                                next_s = SHIFT;
      end
      BLANK: next_s = LATCH;
      LATCH: next_s = DISPLAY;
      DISPLAY: begin
        if (on_cnt_r == ON_LAST) begin
          // en only matters here: a row that has started always finishes.
          shift_row_next_s = shift_row_r + ROW_BITS'(1'b1);
          if (en) next_s = PREFETCH;
          else    next_s = IDLE;
        end else begin
          on_cnt_next_s = on_cnt_r + OCW'(1'b1);
          next_s        = DISPLAY;
        end
      end
      default: next_s = IDLE;
    endcase
    // Outputs are registered from the next state, so they line up with the
    // state they belong to rather than trailing it by a cycle.
    last_disp_next_s = (next_s == DISPLAY) && (on_cnt_next_s == ON_LAST);
  end

  assign shift_phase0_s = (state_r == SHIFT) && !phase_r;
  assign in_shift_s     = (state_r == SHIFT);

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Column/phase, on-time and row counters.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      col_r       <= {CW{1'b0}};
      phase_r     <= 1'b0;
      on_cnt_r    <= {OCW{1'b0}};
      shift_row_r <= {ROW_BITS{1'b0}};
      row_addr_r  <= {ROW_BITS{1'b0}};
    end else begin
      if (state_r == SHIFT) begin
        phase_r <= ~phase_r;
        // Column advances after the sclk-high half; it wraps to 0 on leaving.
        if (phase_r) col_r <= col_r + CW'(1'b1);
      end else begin
        phase_r <= 1'b0;
        col_r   <= {CW{1'b0}};
      end
      on_cnt_r    <= on_cnt_next_s;
      shift_row_r <= shift_row_next_s;
      if (state_r == LATCH) row_addr_r <= shift_row_r;
    end
  end

  // Registered panel and frame-buffer outputs.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_addr_r    <= {AW{1'b0}};
      sdata_r      <= 6'd0;
      sclk_r       <= 1'b0;
      lat_r        <= 1'b0;
      oe_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      // Read one column ahead: the address for column c+1 goes out while
      // column c is clocked, so its data is back in time for the next load.
      if (next_s == PREFETCH) begin
        rd_addr_r <= {shift_row_next_s, {CW{1'b0}}};
      end else if (shift_phase0_s) begin
        rd_addr_r <= {shift_row_r, col_r + CW'(1'b1)};
      end
      if (shift_phase0_s) sdata_r <= rd_data;
      sclk_r       <= shift_phase0_s;
      lat_r        <= (next_s == LATCH);
      oe_n_r       <= (next_s != DISPLAY);
      frame_done_r <= last_disp_next_s && (shift_row_r == ROW_LAST);
    end
  end

  assign rd_addr    = rd_addr_r;
  assign sdata      = sdata_r;
  assign sclk       = sclk_r;
  assign lat        = lat_r;
  assign oe_n       = oe_n_r;
  assign row_addr   = row_addr_r;
  assign frame_done = frame_done_r;

  led_scan_ctrl_chk u_chk (
    .clk      (clk),
    .RST      (RST),
    .lat      (lat_r),
    .oe_n     (oe_n_r),
    .sclk     (sclk_r),
    .in_shift (in_shift_s)
  );

endmodule
